cipher_input_loader: RTL and testbench



---
 rtl/cipher_input_loader.sv | 177 +++++++++++++++++
 tb/tb_cipher_input_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_input_loader.sv
// ---------------------------------------------------------------------------
// cipher_input_loader
//   Beat-serial loader. It assembles a plaintext block and a key from narrow
//   input beats and hands them to the block-cipher core. The first beat
//   accepted lands in the MSBs of each assembled word.
//
//   Optional build macro: LOADER_TIMEOUT_EN. When it is defined, a LOAD that
//   sees TIMEOUT consecutive idle cycles is abandoned and err pulses for one
//   cycle. When it is undefined, err is tied to 0.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   start          begin a new load (sampled in IDLE only)
//   key_load       sampled with start: 1 = reload key, 0 = keep key_out
//   din, kin       plaintext / key beats
//   in_valid       beat valid
//   in_ready       loader accepts beats (state LOAD)
//   data_out       assembled block
//   key_out        assembled key
//   out_valid      block/key complete and held
//   out_ready      consumer accepts the block
//   busy           state != IDLE
//   err            one-cycle timeout pulse
// ---------------------------------------------------------------------------
module cipher_input_loader #(
    parameter int DIN_W   = 4,
    parameter int KIN_W   = 8,
    parameter int BLK_W   = 32,
    parameter int KEY_W   = 64,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             key_load,
    input  logic [DIN_W-1:0] din,
    input  logic [KIN_W-1:0] kin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BLK_W-1:0] data_out,
    output logic [KEY_W-1:0] key_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             err
);
    localparam int DATA_BEATS = BLK_W / DIN_W;
    localparam int KEY_BEATS  = KEY_W / KIN_W;
    localparam int DCW        = $clog2(DATA_BEATS + 1);
    localparam int KCW        = $clog2(KEY_BEATS + 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(DATA_BEATS);
    localparam logic [KCW-1:0] K_LAST = KCW'(KEY_BEATS);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t           state, state_n;
    logic [DCW-1:0]   dcnt, dcnt_n;
    logic [KCW-1:0]   kcnt, kcnt_n;
    logic             kl, kl_n;
    logic [BLK_W-1:0] data_n;
    logic [KEY_W-1:0] key_n;
    logic             err_n;
    logic             accept;

`ifdef LOADER_TIMEOUT_EN
    localparam int ICW = $clog2(TIMEOUT + 1);
    localparam logic [ICW-1:0] I_LAST = ICW'(TIMEOUT - 1);
    logic [ICW-1:0]   idle_cnt, idle_n;
`endif

    always_comb begin
        state_n = state;
        data_n  = data_out;
        key_n   = key_out;
        dcnt_n  = dcnt;
        kcnt_n  = kcnt;
        kl_n    = kl;
        err_n   = 1'b0;
        accept  = 1'b0;
`ifdef LOADER_TIMEOUT_EN
        idle_n  = idle_cnt;
`endif
        case (state)
            IDLE: begin
                // Beats presented alongside start are ignored.
                if (start) begin
                    state_n = LOAD;
                    data_n  = '0;
                    dcnt_n  = '0;
                    kl_n    = key_load;
                    if (key_load) begin
                        key_n  = '0;
                        kcnt_n = '0;
                    end
`ifdef LOADER_TIMEOUT_EN
                    idle_n = '0;
`endif
                end
            end
            LOAD: begin
                accept = in_valid && in_ready;
                if (accept) begin
                    // Each side saturates at its own beat count, so unequal
                    // counts just let the longer side keep filling.
                    if (dcnt < D_LAST) begin
                        data_n = {data_out[BLK_W-DIN_W-1:0], din};
                        dcnt_n = dcnt + 1'b1;
                    end
                    if (kl && (kcnt < K_LAST)) begin
                        key_n  = {key_out[KEY_W-KIN_W-1:0], kin};
                        kcnt_n = kcnt + 1'b1;
                    end
                    if ((dcnt_n == D_LAST) && (!kl || (kcnt_n == K_LAST)))
                        state_n = HOLD;
`ifdef LOADER_TIMEOUT_EN
                    idle_n = '0;
`endif
                end
`ifdef LOADER_TIMEOUT_EN
                else if (idle_cnt == I_LAST) begin
                    // This stall is the TIMEOUT-th: abandon the partial load.
                    state_n = IDLE;
                    data_n  = '0;
                    key_n   = '0;
                    dcnt_n  = '0;
                    kcnt_n  = '0;
                    idle_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
`endif
            end
            HOLD: begin
                // start is ignored here, even if it coincides with out_ready.
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Every output is registered; the flags are decoded from the next state
    // so that they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            data_out  <= '0;
            key_out   <= '0;
            dcnt      <= '0;
            kcnt      <= '0;
            kl        <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt  <= '0;
`endif
        end else begin
            state     <= state_n;
            data_out  <= data_n;
            key_out   <= key_n;
            dcnt      <= dcnt_n;
            kcnt      <= kcnt_n;
            kl        <= kl_n;
            in_ready  <= (state_n == LOAD);
            out_valid <= (state_n == HOLD);
            busy      <= (state_n != IDLE);
            err       <= err_n;
`ifdef LOADER_TIMEOUT_EN
            idle_cnt  <= idle_n;
`endif
        end
    end

endmodule

// File: tb/tb_cipher_input_loader.sv
// ---------------------------------------------------------------------------
// tb_cipher_input_loader
//   Directed bench with hand-computed expected values. u0 uses the default
//   widths, u1 uses 8/16/64/128 widths, and u2 uses TIMEOUT=10. All three
//   share clock, reset and the control inputs.
// ---------------------------------------------------------------------------
module tb_cipher_input_loader;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0, key_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0]   din = '0;
    logic [7:0]   kin = '0;
    logic [7:0]   din1 = '0;
    logic [15:0]  kin1 = '0;

    logic         rdy0, ov0, busy0, err0;
    logic [31:0]  data0;
    logic [63:0]  key0;
    logic         rdy1, ov1, busy1, err1;
    logic [63:0]  data1;
    logic [127:0] key1;
    logic         rdy2, ov2, busy2, err2;
    logic [31:0]  data2;
    logic [63:0]  key2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cipher_input_loader u0 (
        .clk(clk), .reset(reset), .start(start), .key_load(key_load),
        .din(din), .kin(kin), .in_valid(in_valid), .in_ready(rdy0),
        .data_out(data0), .key_out(key0), .out_valid(ov0),
        .out_ready(out_ready), .busy(busy0), .err(err0));

    cipher_input_loader #(.DIN_W(8), .KIN_W(16), .BLK_W(64), .KEY_W(128)) u1 (
        .clk(clk), .reset(reset), .start(start), .key_load(key_load),
        .din(din1), .kin(kin1), .in_valid(in_valid), .in_ready(rdy1),
        .data_out(data1), .key_out(key1), .out_valid(ov1),
        .out_ready(out_ready), .busy(busy1), .err(err1));

    cipher_input_loader #(.TIMEOUT(10)) u2 (
        .clk(clk), .reset(reset), .start(start), .key_load(key_load),
        .din(din), .kin(kin), .in_valid(in_valid), .in_ready(rdy2),
        .data_out(data2), .key_out(key2), .out_valid(ov2),
        .out_ready(out_ready), .busy(busy2), .err(err2));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d, input logic [7:0] k);
        in_valid = 1'b1;
        din = d;
        kin = k;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic go(input logic kl);
        start = 1'b1;
        key_load = kl;
        tick();
        start = 1'b0;
        key_load = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [3:0] dv [8];
    int errs_seen;
    int ov_seen;

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_data", 128'(data0), 128'h0);
        chk("rst_key", 128'(key0), 128'h0);
        chk("rst_ov", 128'(ov0), 128'h0);
        chk("rst_rdy", 128'(rdy0), 128'h0);
        chk("rst_busy", 128'(busy0), 128'h0);
        chk("rst_err", 128'(err0), 128'h0);

        // Full load with key, 8 back-to-back beats
        go(1'b1);
        chk("t1_busy", 128'(busy0), 128'h1);
        chk("t1_rdy", 128'(rdy0), 128'h1);
        for (int i = 1; i <= 8; i++) begin
            beat(4'(i), 8'(i));
            if (i == 7) chk("t1_ov_early", 128'(ov0), 128'h0);
        end
        chk("t1_ov", 128'(ov0), 128'h1);
        chk("t1_data", 128'(data0), 128'h12345678);
        chk("t1_key", 128'(key0), 128'h0102030405060708);
        chk("t1_rdy_hold", 128'(rdy0), 128'h0);
        handshake();
        chk("t1_ov_drop", 128'(ov0), 128'h0);
        chk("t1_idle", 128'(busy0), 128'h0);

        // Key reuse: data only, key beats must not disturb key_out
        go(1'b0);
        chk("t2_key_kept", 128'(key0), 128'h0102030405060708);
        chk("t2_data_clr", 128'(data0), 128'h0);
        dv = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
        for (int i = 0; i < 8; i++) beat(dv[i], 8'hFF);
        chk("t2_ov", 128'(ov0), 128'h1);
        chk("t2_data", 128'(data0), 128'h9ABCDEF0);
        chk("t2_key", 128'(key0), 128'h0102030405060708);
        handshake();

        // Stall between beats 4 and 5, then backpressure in HOLD
        go(1'b1);
        for (int i = 1; i <= 4; i++) beat(4'(i), 8'(i));
        for (int i = 0; i < 3; i++) tick();
        chk("t3_stall_data", 128'(data0), 128'h00001234);
        chk("t3_stall_ov", 128'(ov0), 128'h0);
        chk("t3_stall_rdy", 128'(rdy0), 128'h1);
        for (int i = 5; i <= 8; i++) begin
            beat(4'(i), 8'(i));
            if (i == 7) chk("t3_ov_early", 128'(ov0), 128'h0);
        end
        chk("t3_ov", 128'(ov0), 128'h1);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            key_load = 1'b1;
            tick();
            chk("t3_hold_ov", 128'(ov0), 128'h1);
            chk("t3_hold_busy", 128'(busy0), 128'h1);
            chk("t3_hold_data", 128'(data0), 128'h12345678);
            chk("t3_hold_key", 128'(key0), 128'h0102030405060708);
        end
        start = 1'b1;
        handshake();
        start = 1'b0;
        key_load = 1'b0;
        chk("t3_hs_busy", 128'(busy0), 128'h0);
        chk("t3_hs_ov", 128'(ov0), 128'h0);
        tick();
        chk("t3_no_restart", 128'(busy0), 128'h0);

        // Reset mid-load, then a fresh load with no residue
        go(1'b1);
        for (int i = 1; i <= 3; i++) beat(4'(i), 8'(i));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_data", 128'(data0), 128'h0);
        chk("t4_key", 128'(key0), 128'h0);
        chk("t4_busy", 128'(busy0), 128'h0);
        chk("t4_rdy", 128'(rdy0), 128'h0);
        chk("t4_ov", 128'(ov0), 128'h0);
        go(1'b1);
        dv = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1, 4'h2};
        for (int i = 0; i < 8; i++) beat(dv[i], 8'((i + 1) * 8'h11));
        chk("t4b_ov", 128'(ov0), 128'h1);
        chk("t4b_data", 128'(data0), 128'hABCDEF12);
        chk("t4b_key", 128'(key0), 128'h1122334455667788);
        handshake();

        // Wide instance: bytes and halfwords packed first-beat-MSB
        reset = 1'b1;
        tick();
        reset = 1'b0;
        go(1'b1);
        for (int i = 0; i < 8; i++) begin
            din1 = 8'(8'h10 + i);
            kin1 = 16'(16'hA000 + i);
            beat(4'(i), 8'(i));
        end
        chk("t5_ov", 128'(ov1), 128'h1);
        chk("t5_data", 128'(data1), 128'h1011121314151617);
        chk("t5_key", key1, 128'hA000A001A002A003A004A005A006A007);
        handshake();
        chk("t5_idle", 128'(busy1), 128'h0);

        // Timeout instance: two beats then a long stall
        reset = 1'b1;
        tick();
        reset = 1'b0;
        go(1'b1);
        beat(4'h1, 8'h01);
        beat(4'h2, 8'h02);
        errs_seen = 0;
        ov_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (err2) errs_seen++;
            if (ov2) ov_seen++;
        end
        chk("t6_ov_never", 128'(ov_seen), 128'h0);
`ifdef LOADER_TIMEOUT_EN
        chk("t6_err_once", 128'(errs_seen), 128'h1);
        chk("t6_busy", 128'(busy2), 128'h0);
        chk("t6_data", 128'(data2), 128'h0);
        chk("t6_key", 128'(key2), 128'h0);
`else
        chk("t6_err_none", 128'(errs_seen), 128'h0);
        chk("t6_busy", 128'(busy2), 128'h1);
        chk("t6_data", 128'(data2), 128'h12);
        chk("t6_key", 128'(key2), 128'h0102);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
